// File: rtl/mkio_defs.sv
`default_nettype none
// ============================================================================
// mkio_defs : shared definitions for the MKIO remote-terminal sequencer
// Revision  : 1.0
// ============================================================================
package mkio_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_DATA   = 3'd1,
        ST_GAP       = 3'd2,
        ST_TX_STATUS = 3'd3,
        ST_TX_FETCH  = 3'd4,
        ST_TX_DATA   = 3'd5,
        ST_TX_END    = 3'd6
    } seq_state_e;

    localparam int CMD_ADDR_MSB = 15;
    localparam int CMD_ADDR_LSB = 11;
    localparam int CMD_TR_BIT   = 10;
    localparam int CMD_SA_MSB   = 9;
    localparam int CMD_SA_LSB   = 5;
    localparam int CMD_WC_MSB   = 4;
    localparam int CMD_WC_LSB   = 0;

    localparam int STS_ME_BIT   = 10;

    localparam logic [4:0] DEF_RT_ADDR = 5'd1;
    localparam logic [4:0] DEF_SA_RX   = 5'd3;
    localparam logic [4:0] DEF_SA_TX   = 5'd5;

    // Field layout matches the CMD_* offsets above.
    typedef struct packed {
        logic [4:0] addr;
        logic       tr;
        logic [4:0] sa;
        logic [4:0] wc;
    } cmd_t;

    function automatic logic [5:0] wc_count(input logic [4:0] wc);
        return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mkio_seq_timer.sv
`default_nettype none
// ============================================================================
// mkio_seq_timer : loadable down-counter, stops at zero
// Revision       : 1.0
// ============================================================================
module mkio_seq_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/mkio_rt_seq.sv
`default_nettype none
// ============================================================================
// mkio_rt_seq : MIL-STD-1553B remote-terminal message sequencer
// Revision    : 1.0
// ============================================================================
module mkio_rt_seq
    import mkio_defs::*;
#(
    parameter logic [4:0] RT_ADDR    = DEF_RT_ADDR,
    parameter logic [4:0] SA_RX      = DEF_SA_RX,
    parameter logic [4:0] SA_TX      = DEF_SA_TX,
    parameter int         RESP_GAP   = 160,
    parameter int         RX_TIMEOUT = 768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic        rx_csw,
    input  logic [15:0] rx_data,
    input  logic        rx_err,
    output logic        tx_req,
    output logic        tx_csw,
    output logic [15:0] tx_data,
    input  logic        tx_ack,
    input  logic        tx_done,
    output logic        mem_wr_en,
    output logic [4:0]  mem_wr_addr,
    output logic [15:0] mem_wr_data,
    output logic [4:0]  mem_rd_addr,
    input  logic [15:0] mem_rd_data,
    output logic        busy_rx,
    output logic        busy_tx
);

    localparam int TMR_MAX = (RX_TIMEOUT > RESP_GAP) ? RX_TIMEOUT : RESP_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    // Timer counts down to zero, so load one less than the wanted span.
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(RESP_GAP - 1);
    localparam logic [TMR_W-1:0] RXTO_LOAD = TMR_W'(RX_TIMEOUT - 1);

    seq_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  wptr_q, wptr_d;
    logic [4:0]  rptr_q, rptr_d;
    logic        me_q, me_d;
    logic        tx_cmd_q, tx_cmd_d;
    logic        busy_rx_q, busy_rx_d;
    logic        busy_tx_q, busy_tx_d;
    logic [1:0]  pend_q, pend_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             w_tmr_zero;
    logic             take_cmd;
    cmd_t             w_cmd;
    logic             w_cmd_valid;
    logic [15:0]      w_status;

    assign w_cmd       = cmd_t'(rx_data);
    assign w_cmd_valid = rx_valid & rx_csw & ~rx_err;

    always_comb begin
        w_status                            = '0;
        w_status[CMD_ADDR_MSB:CMD_ADDR_LSB] = RT_ADDR;
        w_status[STS_ME_BIT]                = me_q;
    end

    mkio_seq_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (w_tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        me_d      = me_q;
        tx_cmd_d  = tx_cmd_q;
        busy_rx_d = busy_rx_q;
        busy_tx_d = busy_tx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        tmr_load  = 1'b0;
        tmr_val   = GAP_LOAD;
        take_cmd  = 1'b0;
        tx_req    = 1'b0;
        tx_csw    = 1'b0;
        tx_data   = '0;

        // Encoder is double-buffered: track words accepted but not yet shifted out.
        pend_d = pend_q;
        if (tx_ack) begin
            pend_d = pend_d + 2'd1;
        end
        if (tx_done && pend_q != 2'd0) begin
            pend_d = pend_d - 2'd1;
        end

        case (state_q)
            ST_IDLE: begin
                pend_d   = '0;
                take_cmd = w_cmd_valid;
            end
            ST_RX_DATA: begin
                if (rx_valid && rx_err) begin
                    state_d   = ST_IDLE;
                    me_d      = 1'b1;
                    busy_rx_d = 1'b0;
                end else if (rx_valid && rx_csw) begin
                    state_d   = ST_IDLE;
                    me_d      = 1'b1;
                    busy_rx_d = 1'b0;
                    take_cmd  = 1'b1;
                end else if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wptr_q;
                    wr_data_d = rx_data;
                    wptr_d    = wptr_q + 5'd1;
                    cnt_d     = cnt_q - 6'd1;
                    tmr_load  = 1'b1;
                    tmr_val   = RXTO_LOAD;
                    if (cnt_q == 6'd1) begin
                        state_d = ST_GAP;
                        tmr_val = GAP_LOAD;
                    end
                end else if (w_tmr_zero) begin
                    state_d   = ST_IDLE;
                    me_d      = 1'b1;
                    busy_rx_d = 1'b0;
                end
            end
            ST_GAP: begin
                if (w_tmr_zero) begin
                    state_d = ST_TX_STATUS;
                end
            end
            ST_TX_STATUS: begin
                tx_req  = 1'b1;
                tx_csw  = 1'b1;
                tx_data = w_status;
                if (tx_ack) begin
                    me_d    = 1'b0;
                    state_d = tx_cmd_q ? ST_TX_FETCH : ST_TX_END;
                end
            end
            ST_TX_FETCH: begin
                state_d = ST_TX_DATA;
            end
            ST_TX_DATA: begin
                tx_req  = 1'b1;
                tx_data = mem_rd_data;
                if (tx_ack) begin
                    rptr_d  = rptr_q + 5'd1;
                    cnt_d   = cnt_q - 6'd1;
                    state_d = (cnt_q == 6'd1) ? ST_TX_END : ST_TX_FETCH;
                end
            end
            ST_TX_END: begin
                if (tx_done && pend_q == 2'd1) begin
                    state_d   = ST_IDLE;
                    busy_rx_d = 1'b0;
                    busy_tx_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Command decode shared by IDLE and the supersede path in RX_DATA.
        if (take_cmd && w_cmd.addr == RT_ADDR) begin
            cnt_d    = wc_count(w_cmd.wc);
            tmr_load = 1'b1;
            if (!w_cmd.tr && w_cmd.sa == SA_RX) begin
                state_d   = ST_RX_DATA;
                wptr_d    = '0;
                busy_rx_d = 1'b1;
                tx_cmd_d  = 1'b0;
                tmr_val   = RXTO_LOAD;
            end else if (w_cmd.tr && w_cmd.sa == SA_TX) begin
                state_d   = ST_GAP;
                rptr_d    = '0;
                busy_tx_d = 1'b1;
                tx_cmd_d  = 1'b1;
            end else begin
                state_d  = ST_GAP;
                me_d     = 1'b1;
                tx_cmd_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            me_q      <= 1'b0;
            tx_cmd_q  <= 1'b0;
            busy_rx_q <= 1'b0;
            busy_tx_q <= 1'b0;
            pend_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            me_q      <= me_d;
            tx_cmd_q  <= tx_cmd_d;
            busy_rx_q <= busy_rx_d;
            busy_tx_q <= busy_tx_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign mem_rd_addr = rptr_q;
    assign busy_rx     = busy_rx_q;
    assign busy_tx     = busy_tx_q;

endmodule
`default_nettype wire

// File: tb/tb_mkio_rt_seq.sv
`default_nettype none
// ============================================================================
// tb_mkio_rt_seq : directed bench with message-level reference model
// Revision       : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mkio_rt_seq;

    localparam int RESP_GAP   = 160;
    localparam int RX_TIMEOUT = 768;
    localparam int SHIFT      = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid, rx_csw, rx_err;
    logic [15:0] rx_data;
    logic        tx_req, tx_csw;
    logic [15:0] tx_data;
    logic        tx_ack, tx_done;
    logic        mem_wr_en;
    logic [4:0]  mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic [4:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        busy_rx, busy_tx;

    always #5 clk = ~clk;

    mkio_rt_seq dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_csw      (rx_csw),
        .rx_data     (rx_data),
        .rx_err      (rx_err),
        .tx_req      (tx_req),
        .tx_csw      (tx_csw),
        .tx_data     (tx_data),
        .tx_ack      (tx_ack),
        .tx_done     (tx_done),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .busy_rx     (busy_rx),
        .busy_tx     (busy_tx)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] dev5 [32];
    always @(posedge clk) mem_rd_data <= dev5[mem_rd_addr];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (message level) ----------------
    typedef struct { int addr; logic [15:0] data; int cyc; } wr_t;
    typedef struct { logic csw; logic [15:0] data; int cyc; } tx_t;
    wr_t exp_wr[$];
    tx_t exp_tx[$];
    bit  m_rx = 0;
    bit  m_me = 0;
    int  m_left, m_wptr;
    int  last_rx_cyc;

    task automatic respond(input int c, input int n);
        exp_tx.push_back('{csw: 1'b1, data: {5'd1, m_me, 10'd0}, cyc: c + RESP_GAP + 1});
        m_me = 0;
        for (int i = 0; i < n; i++) exp_tx.push_back('{csw: 1'b0, data: dev5[i], cyc: -1});
    endtask

    task automatic model_cmd(input logic [15:0] w, input int c);
        int wc;
        if (w[15:11] != 5'd1) return;
        wc = (w[4:0] == 5'd0) ? 32 : int'(w[4:0]);
        if (!w[10] && w[9:5] == 5'd3) begin
            m_rx = 1; m_left = wc; m_wptr = 0;
        end else if (w[10] && w[9:5] == 5'd5) begin
            respond(c, wc);
        end else begin
            m_me = 1;
            respond(c, 0);
        end
    endtask

    task automatic send_word(input logic csw, input logic [15:0] d, input logic err);
        int c;
        @(negedge clk);
        rx_valid = 1; rx_csw = csw; rx_data = d; rx_err = err;
        c = cyc; last_rx_cyc = c;
        if (m_rx) begin
            if (err) begin
                m_rx = 0; m_me = 1;
            end else if (csw) begin
                m_rx = 0; m_me = 1;
                model_cmd(d, c);
            end else begin
                exp_wr.push_back('{addr: m_wptr, data: d, cyc: c + 1});
                m_wptr++; m_left--;
                if (m_left == 0) begin
                    m_rx = 0;
                    respond(c, 0);
                end
            end
        end else if (csw && !err) begin
            model_cmd(d, c);
        end
        @(negedge clk);
        rx_valid = 0; rx_csw = 0; rx_err = 0;
    endtask

    task automatic silence(input int n);
        repeat (n) @(negedge clk);
        if (m_rx && n >= RX_TIMEOUT) begin
            m_rx = 0; m_me = 1;
        end
    endtask

    // ---------------- encoder model (double-buffered) ----------------
    bit enc_hold = 0;
    int enc_sh = 0;
    int ack_cyc = 0;

    initial begin
        tx_ack = 0; tx_done = 0;
        forever begin
            @(negedge clk);
            tx_ack = 0; tx_done = 0;
            if (reset) begin
                enc_hold = 0; enc_sh = 0;
            end else begin
                if (enc_sh > 0) begin
                    enc_sh--;
                    if (enc_sh == 0) tx_done = 1;
                end
                if (enc_sh == 0 && enc_hold) begin
                    enc_hold = 0; enc_sh = SHIFT;
                end
                if (tx_req && !enc_hold) begin
                    enc_hold = 1; tx_ack = 1; ack_cyc = cyc;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int          wr_seen = 0;
    int          tx_seen = 0;
    logic [15:0] obs_status = '0;
    int          obs_status_cyc = 0;

    initial begin
        logic        prev_req;
        logic [15:0] held;
        wr_t         e;
        tx_t         t;
        prev_req = 0;
        held = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_wr_en === 1'b1) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    check("unexpected_wr", mem_wr_en, 0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", mem_wr_addr, e.addr);
                    check("wr_data", mem_wr_data, e.data);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
            if (tx_req === 1'b1 && !prev_req) begin
                tx_seen++;
                if (exp_tx.size() == 0) begin
                    check("unexpected_tx_req", tx_req, 0);
                end else begin
                    t = exp_tx.pop_front();
                    check("tx_csw", tx_csw, t.csw);
                    check("tx_data", tx_data, t.data);
                    if (t.cyc >= 0) check("status_cycle", cyc, t.cyc);
                    else            check("ack_to_req_latency", cyc - ack_cyc, 2);
                    if (t.csw) begin
                        obs_status = tx_data;
                        obs_status_cyc = cyc;
                    end
                end
                held = tx_data;
            end else if (tx_req === 1'b1) begin
                check("tx_data_stable", tx_data, held);
            end
            prev_req = (tx_req === 1'b1);
        end
    end

    // Waits for the final tx_done of a response; checks busy before and after it.
    task automatic wait_msg_done(input string name, input logic erx, input logic etx);
        bit   seen;
        logic pbrx, pbtx;
        seen = 0; pbrx = 0; pbtx = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(posedge clk); #1;
            if (tx_done && exp_tx.size() == 0 && !enc_hold && enc_sh == 0) begin
                seen = 1;
                check({name, "_busy_rx_before_done"}, pbrx, erx);
                check({name, "_busy_tx_before_done"}, pbtx, etx);
                check({name, "_busy_clear"}, {busy_rx, busy_tx}, 2'b00);
                check({name, "_writes_drained"}, exp_wr.size(), 0);
            end
            pbrx = busy_rx; pbtx = busy_tx;
        end
        check({name, "_completed"}, seen, 1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int  w0, t0;
        bit  found;
        for (int i = 0; i < 32; i++) dev5[i] = 16'hC000 | 16'(i * 313);
        reset = 1; rx_valid = 0; rx_csw = 0; rx_err = 0; rx_data = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {tx_req, tx_csw, tx_data, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr, busy_rx, busy_tx}, 64'd0);
        reset = 0;

        // T1: receive 7 words into DEV3
        w0 = wr_seen;
        send_word(1, 16'h0867, 0);
        check("t1_busy_rx_rise", {busy_rx, busy_tx}, 2'b10);
        for (int k = 0; k < 7; k++) send_word(0, 16'h1000 + 16'(k * 16'h0101), 0);
        wait_msg_done("t1", 1, 0);
        check("t1_write_count", wr_seen - w0, 7);
        check("t1_status", obs_status, 16'h0800);
        check("t1_status_gap", obs_status_cyc - last_rx_cyc, 161);

        // T2: transmit 5 words from DEV5
        t0 = tx_seen;
        send_word(1, 16'h0CA5, 0);
        check("t2_busy_tx_rise", {busy_rx, busy_tx}, 2'b01);
        wait_msg_done("t2", 0, 1);
        check("t2_status", obs_status, 16'h0800);
        check("t2_word_count", tx_seen - t0, 6);

        // T3: other terminal and broadcast are ignored
        w0 = wr_seen; t0 = tx_seen;
        send_word(1, 16'h1067, 0);
        send_word(1, 16'hF867, 0);
        repeat (300) @(negedge clk);
        check("t3_no_activity", {wr_seen - w0, tx_seen - t0}, 64'd0);
        check("t3_busy", {busy_rx, busy_tx}, 2'b00);

        // T4: timeout abort, then ME reported on next status
        t0 = tx_seen;
        send_word(1, 16'h0867, 0);
        for (int k = 0; k < 3; k++) send_word(0, 16'h2000 + 16'(k), 0);
        silence(800);
        check("t4_busy_after_timeout", busy_rx, 0);
        check("t4_no_response", tx_seen - t0, 0);
        send_word(1, 16'h0CA5, 0);
        wait_msg_done("t4", 0, 1);
        check("t4_status_me", obs_status, 16'h0C00);

        // wc=0 means 32 words; status shows ME was cleared
        w0 = wr_seen;
        send_word(1, 16'h0860, 0);
        for (int k = 0; k < 32; k++) send_word(0, 16'h3000 ^ 16'(k * 16'h0041), 0);
        wait_msg_done("t32", 1, 0);
        check("t32_write_count", wr_seen - w0, 32);
        check("t32_status", obs_status, 16'h0800);

        // Illegal subaddress: status only, ME set
        t0 = tx_seen;
        send_word(1, 16'h0C62, 0);
        wait_msg_done("till", 0, 0);
        check("till_status", obs_status, 16'h0C00);
        check("till_word_count", tx_seen - t0, 1);

        // T5: rx_err on data word 2
        w0 = wr_seen; t0 = tx_seen;
        send_word(1, 16'h0867, 0);
        send_word(0, 16'h4001, 0);
        send_word(0, 16'h4002, 0);
        send_word(0, 16'h4003, 1);
        check("t5_busy_drop", busy_rx, 0);
        repeat (300) @(negedge clk);
        check("t5_write_count", wr_seen - w0, 2);
        check("t5_no_response", tx_seen - t0, 0);

        // Supersede: a new command during RX_DATA
        send_word(1, 16'h0867, 0);
        send_word(0, 16'h5001, 0);
        send_word(1, 16'h0CA5, 0);
        wait_msg_done("tsup", 0, 1);
        check("tsup_status", obs_status, 16'h0C00);

        // T6: reset while TX_DATA waits for ack
        send_word(1, 16'h0CA5, 0);
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(posedge clk); #1;
            if (tx_req && !tx_csw && enc_hold && enc_sh > 5) found = 1;
        end
        check("t6_stall_reached", found, 1);
        @(negedge clk);
        reset = 1;
        exp_tx.delete(); exp_wr.delete();
        m_rx = 0; m_me = 0;
        @(posedge clk); #1;
        check("t6_reset_outputs",
              {tx_req, tx_csw, tx_data, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr, busy_rx, busy_tx}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        repeat (5) @(negedge clk);
        t0 = tx_seen;
        send_word(1, 16'h0CA5, 0);
        wait_msg_done("t6", 0, 1);
        check("t6_status", obs_status, 16'h0800);
        check("t6_word_count", tx_seen - t0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
